// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: controller states
// and default datapath width / divide factor.
package clk_div_pkg;

    localparam int unsigned CNT_W_DEF       = 16;
    localparam int unsigned DEFAULT_DIV_DEF = 4;

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_RUN      = 2'd1,
        ST_PEND     = 2'd2,
        ST_STOPPING = 2'd3
    } state_e;

    // Even and non-zero; odd or zero factors cannot give a 50% duty cycle.
    function automatic logic div_is_legal(input logic [CNT_W_DEF-1:0] n);
        return (n[0] == 1'b0) && (n != '0);
    endfunction

endpackage

// File: rtl/clk_div_phase.sv
// Phase counter and output toggle register: counts 1..H, toggles the divided
// clock at H and emits a tick on every rising toggle.
module clk_div_phase
    import clk_div_pkg::*;
#(
    parameter int unsigned P_CNT_W    = CNT_W_DEF,
    parameter int unsigned P_RST_HALF = DEFAULT_DIV_DEF / 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic               i_run,
    input  logic               i_load,
    input  logic [P_CNT_W-1:0] i_half,
    output logic               o_clk,
    output logic               o_tick,
    output logic               o_fall_c
);

    logic [P_CNT_W-1:0] cnt_q, cnt_d;
    logic [P_CNT_W-1:0] half_q, half_d;
    logic               clk_q, clk_d;
    logic               tick_q, tick_d;
    logic               at_half_c;

    assign at_half_c = (cnt_q == half_q);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q  <= P_CNT_W'(1);
            half_q <= P_CNT_W'(P_RST_HALF);
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    // The compare uses the half-period in force; a load only affects the next phase.
    always_comb begin
        cnt_d  = cnt_q;
        half_d = half_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (i_load) begin
            half_d = i_half;
        end
        if (i_clear) begin
            cnt_d = P_CNT_W'(1);
            clk_d = 1'b0;
        end else if (i_run) begin
            if (at_half_c) begin
                cnt_d  = P_CNT_W'(1);
                clk_d  = ~clk_q;
                tick_d = ~clk_q;
            end else begin
                cnt_d = cnt_q + P_CNT_W'(1);
            end
        end
    end

    assign o_clk    = clk_q;
    assign o_tick   = tick_q;
    assign o_fall_c = at_half_c & clk_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider controller: run/stop FSM, divide-factor
// handshake with glitch-free factor changes, and sticky illegal-factor flag.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned P_CNT_W       = CNT_W_DEF,
    parameter int unsigned P_DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_enable,
    input  logic               i_div_valid,
    input  logic [P_CNT_W-1:0] i_div_data,
    output logic               o_div_ready,
    input  logic               i_err_clr,
    output logic               o_clk,
    output logic               o_tick,
    output logic               o_running,
    output logic [P_CNT_W-1:0] o_div_cur,
    output logic               o_err
);

    state_e             state_q, state_d;
    logic [P_CNT_W-1:0] div_cur_q, div_cur_d;
    logic [P_CNT_W-1:0] pend_q, pend_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;
    logic               running_q, running_d;

    logic               accept_c;
    logic               legal_c;
    logic               illegal_c;
    logic               ph_clear;
    logic               ph_run;
    logic               ph_load;
    logic [P_CNT_W-1:0] ph_half;
    logic               ph_clk;
    logic               ph_fall_c;

    assign accept_c  = i_div_valid & ready_q;
    assign legal_c   = accept_c & (i_div_data[0] == 1'b0) & (i_div_data != '0);
    assign illegal_c = accept_c & ~legal_c;
    assign ph_half   = div_cur_d >> 1;

    clk_div_phase #(
        .P_CNT_W    (P_CNT_W),
        .P_RST_HALF (P_DEFAULT_DIV / 2)
    ) u_phase (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (ph_clear),
        .i_run    (ph_run),
        .i_load   (ph_load),
        .i_half   (ph_half),
        .o_clk    (ph_clk),
        .o_tick   (o_tick),
        .o_fall_c (ph_fall_c)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_OFF;
            div_cur_q <= P_CNT_W'(P_DEFAULT_DIV);
            pend_q    <= P_CNT_W'(P_DEFAULT_DIV);
            err_q     <= 1'b0;
            ready_q   <= 1'b1;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cur_q <= div_cur_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            running_q <= running_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_cur_d = div_cur_q;
        pend_d    = pend_q;
        err_d     = err_q;
        ph_clear  = 1'b0;
        ph_run    = 1'b0;
        ph_load   = 1'b0;

        // An illegal transfer in the same cycle as a clear keeps the flag set.
        if (i_err_clr) begin
            err_d = 1'b0;
        end
        if (illegal_c) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_OFF: begin
                ph_clear = 1'b1;
                if (legal_c) begin
                    div_cur_d = i_div_data;
                    ph_load   = 1'b1;
                end
                if (i_enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!i_enable && !ph_clk) begin
                    // Low phase can be cut short without a glitch.
                    ph_clear = 1'b1;
                    state_d  = ST_OFF;
                    if (legal_c) begin
                        div_cur_d = i_div_data;
                        ph_load   = 1'b1;
                    end
                end else begin
                    ph_run = 1'b1;
                    if (legal_c) begin
                        pend_d  = i_div_data;
                        state_d = ST_PEND;
                    end else if (!i_enable) begin
                        state_d = ph_fall_c ? ST_OFF : ST_STOPPING;
                    end
                end
            end
            ST_PEND: begin
                ph_run = 1'b1;
                if (ph_fall_c) begin
                    div_cur_d = pend_q;
                    ph_load   = 1'b1;
                    state_d   = i_enable ? ST_RUN : ST_OFF;
                end
            end
            ST_STOPPING: begin
                ph_run = 1'b1;
                if (ph_fall_c) begin
                    state_d = ST_OFF;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase

        ready_d   = (state_d == ST_OFF) || (state_d == ST_RUN);
        running_d = (state_d != ST_OFF);
    end

    assign o_clk       = ph_clk;
    assign o_div_ready = ready_q;
    assign o_running   = running_q;
    assign o_div_cur   = div_cur_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed and randomized bench for clk_div_ctrl against a phase-length
// reference model.
module tb_clk_div_ctrl;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         v;
    logic [W-1:0] d;
    logic         clr;
    logic         o_div_ready;
    logic         o_clk;
    logic         o_tick;
    logic         o_running;
    logic [W-1:0] o_div_cur;
    logic         o_err;

    int checks = 0;
    int errors = 0;

    // Reference model: level of the divided clock and cycles left in the phase.
    bit m_on, m_lvl, m_tick, m_pend_v, m_stop, m_err;
    int m_div, m_pend, m_left;

    logic prev_clk;
    int   run_len, last_len;

    logic [W-1:0] vals [9] = '{16'd2, 16'd4, 16'd6, 16'd8, 16'd3, 16'd0, 16'd5, 16'd12, 16'd7};

    always #5 clk = ~clk;

    clk_div_ctrl dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_enable    (en),
        .i_div_valid (v),
        .i_div_data  (d),
        .o_div_ready (o_div_ready),
        .i_err_clr   (clr),
        .o_clk       (o_clk),
        .o_tick      (o_tick),
        .o_running   (o_running),
        .o_div_cur   (o_div_cur),
        .o_err       (o_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_lvl = 0; m_tick = 0; m_pend_v = 0; m_stop = 0; m_err = 0;
        m_div = 4; m_pend = 0; m_left = 0;
    endtask

    task automatic model_step();
        bit ready, acc, legal, pb, fall;
        ready = !(m_pend_v || m_stop);
        acc   = v && ready;
        legal = acc && (int'(d) % 2 == 0) && (d != 0);
        pb    = m_pend_v;
        if (clr) m_err = 0;
        if (acc && !legal) m_err = 1;
        m_tick = 0;
        if (!m_on) begin
            if (legal) m_div = int'(d);
            if (en) begin
                m_on = 1; m_lvl = 0; m_left = m_div / 2;
            end
        end else if (!pb && !m_stop && !en && !m_lvl) begin
            m_on = 0;
            if (legal) m_div = int'(d);
        end else begin
            if (legal) begin
                m_pend_v = 1; m_pend = int'(d);
            end else if (!pb && !m_stop && !en) begin
                m_stop = 1;
            end
            m_left--;
            if (m_left == 0) begin
                fall  = m_lvl;
                m_lvl = !m_lvl;
                if (!fall) m_tick = 1;
                if (fall && pb) begin
                    m_div = m_pend; m_pend_v = 0;
                    if (!en) m_on = 0;
                end
                if (fall && m_stop) begin
                    m_stop = 0; m_on = 0;
                end
                m_left = m_div / 2;
            end
        end
    endtask

    task automatic compare_all();
        chk("o_clk", 32'(o_clk), 32'(m_lvl));
        chk("o_tick", 32'(o_tick), 32'(m_tick));
        chk("o_running", 32'(o_running), 32'(m_on));
        chk("o_div_ready", 32'(o_div_ready), 32'(!(m_pend_v || m_stop)));
        chk("o_div_cur", 32'(o_div_cur), 32'(m_div));
        chk("o_err", 32'(o_err), 32'(m_err));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
        compare_all();
        if (o_clk !== prev_clk) begin
            last_len = run_len; run_len = 1; prev_clk = o_clk;
        end else begin
            run_len++;
        end
    endtask

    task automatic send(input logic [W-1:0] n);
        for (int i = 0; i < 200 && !o_div_ready; i++) step();
        chk("ready_wait", 32'(o_div_ready), 32'd1);
        v = 1'b1; d = n;
        step();
        v = 1'b0;
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 200 && !o_tick; i++) step();
        chk("tick_wait", 32'(o_tick), 32'd1);
    endtask

    task automatic wait_off();
        for (int i = 0; i < 200 && o_running; i++) step();
        chk("off_wait", 32'(o_running), 32'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; v = 1'b0; d = '0; clr = 1'b0;
        model_reset();
        prev_clk = 1'b0; run_len = 0; last_len = 0;
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        // Default factor 4: 2 high, 2 low
        en = 1'b1;
        repeat (13) step();
        chk("div4_phase", 32'(last_len), 32'd2);

        // Factor 6 offered during a high phase
        for (int i = 0; i < 10 && !o_clk; i++) step();
        chk("high_before_6", 32'(o_clk), 32'd1);
        send(16'd6);
        chk("pend_not_ready", 32'(o_div_ready), 32'(o_clk ? 1'b0 : o_div_ready));
        repeat (16) step();
        chk("div_cur_6", 32'(o_div_cur), 32'd6);
        chk("div6_phase", 32'(last_len), 32'd3);

        // Illegal factors leave the factor in force untouched
        send(16'd4);
        repeat (20) step();
        send(16'd5);
        chk("err_odd", 32'(o_err), 32'd1);
        chk("div_kept_odd", 32'(o_div_cur), 32'd4);
        clr = 1'b1; step(); clr = 1'b0;
        chk("err_cleared", 32'(o_err), 32'd0);
        send(16'd0);
        chk("err_zero", 32'(o_err), 32'd1);
        chk("div_kept_zero", 32'(o_div_cur), 32'd4);
        clr = 1'b1;
        send(16'd3);
        clr = 1'b0;
        chk("err_clr_collide", 32'(o_err), 32'd1);
        clr = 1'b1; step(); clr = 1'b0;
        chk("err_cleared2", 32'(o_err), 32'd0);

        // Stop one cycle into a high phase at factor 8
        send(16'd8);
        repeat (24) step();
        chk("div_cur_8", 32'(o_div_cur), 32'd8);
        wait_tick();
        en = 1'b0;
        repeat (12) step();
        chk("stop_high_len", 32'(last_len), 32'd4);
        chk("stop_running", 32'(o_running), 32'd0);

        // Asynchronous reset while a factor is pending in a high phase
        en = 1'b1;
        wait_tick();
        send(16'd10);
        chk("pend_high", 32'(o_clk), 32'd1);
        chk("pend_ready", 32'(o_div_ready), 32'd0);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_clk", 32'(o_clk), 32'd0);
        chk("arst_div", 32'(o_div_cur), 32'd4);
        chk("arst_running", 32'(o_running), 32'd0);
        chk("arst_ready", 32'(o_div_ready), 32'd1);
        step();
        rst = 1'b0;
        repeat (24) step();
        chk("no_pend_apply", 32'(o_div_cur), 32'd4);

        // Boundary factors 2 and 65534
        en = 1'b0;
        wait_off();
        send(16'd2);
        en = 1'b1;
        repeat (10) step();
        chk("div2_phase", 32'(last_len), 32'd1);
        en = 1'b0;
        wait_off();
        send(16'd65534);
        en = 1'b1;
        repeat (65540) step();
        chk("div_max_phase", 32'(last_len), 32'd32767);
        chk("div_max_cur", 32'(o_div_cur), 32'd65534);
        en = 1'b0;
        wait_off();

        // Randomized traffic
        send(16'd4);
        en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            v   = ($urandom_range(0, 9) == 0);
            d   = vals[$urandom_range(0, 8)];
            clr = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter P_CNT_W, default 16: width of the divide-factor and phase-counter datapath.
REQ-002 Parameter P_DEFAULT_DIV, default 4: divide factor loaded at reset; even, at least 2.
REQ-003 i_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 i_rst  input  1  reset; asynchronous, active-high.
REQ-005 i_enable  input  1  level run request for the divided clock.
REQ-006 i_div_valid  input  1  new divide factor offered.
REQ-007 i_div_data  input  P_CNT_W  offered divide factor N.
REQ-008 o_div_ready  output  1  controller can accept a factor this cycle.
REQ-009 i_err_clr  input  1  clears o_err.
REQ-010 o_clk  output  1  divided clock; registered, glitch-free.
REQ-011 o_tick  output  1  one-cycle pulse in the cycle o_clk is driven 0->1.
REQ-012 o_running  output  1  high in RUN, PEND and STOPPING.
REQ-013 o_div_cur  output  P_CNT_W  divide factor currently in force.
REQ-014 o_err  output  1  sticky flag for an illegal factor.

Function
REQ-015 Half-period H = o_div_cur/2; the phase counter runs 1..H; at H it reloads to 1 and o_clk toggles.
REQ-016 States:
- OFF: o_clk=0, counter=1.
- RUN.
- PEND: a new factor is held.
- STOPPING.
REQ-017 OFF->RUN on i_enable=1; the first o_clk rise occurs on the H-th cycle in RUN, so o_clk period = N cycles with a 50% duty cycle.
REQ-018 Handshake: the transfer occurs when i_div_valid && o_div_ready; o_div_ready=1 in OFF and RUN, 0 in PEND and STOPPING.
REQ-019 Legal N is even and at least 2; an illegal N is still accepted, sets o_err=1 the next cycle, is discarded, and causes no state change.
REQ-020 Legal N accepted in OFF sets o_div_cur=N on the next cycle.
REQ-021 Legal N accepted in RUN is stored; RUN->PEND.
REQ-022 In PEND, at the falling toggle (counter==H, o_clk=1), o_div_cur takes the pending N and the counter reloads to 1; the following low phase uses the new H; PEND->RUN.
REQ-023 Every o_clk phase lasts exactly H cycles of either the old or the new factor, never a mix.
REQ-024 RUN with i_enable=0:
- if o_clk=0, go to OFF next cycle with the counter reset to 1;
- if o_clk=1, go to STOPPING.
REQ-025 STOPPING completes the high phase; at the falling toggle it goes to OFF; i_enable reasserted in STOPPING has no effect until OFF is reached.
REQ-026 PEND with i_enable=0: the pending factor is applied at the next falling toggle, then the block goes to OFF.
REQ-027 i_err_clr clears o_err; a simultaneous illegal transfer wins and o_err stays 1.
REQ-028 Counter arithmetic is unsigned P_CNT_W with no wrap; the maximum legal N is 2^P_CNT_W-2.

Reset
REQ-029 i_rst=1 immediately forces all of the following, regardless of state:
- state=OFF
- counter=1
- o_clk=0
- o_tick=0
- o_running=0
- o_err=0
- o_div_cur=P_DEFAULT_DIV
- o_div_ready=1
- any pending factor discarded.
REQ-030 After i_rst deasserts, operation resumes on the first rising edge of i_clk.

Structure
REQ-031 Shared package clk_div_pkg holds the state enumeration, the default P_CNT_W and the default P_DEFAULT_DIV.
REQ-032 The phase counter and toggle register form one sub-module, clk_div_phase, with a load input for H; clk_div_ctrl holds the FSM, handshake and error logic.

Verification
REQ-033 Reset, then i_enable=1 with the default factor 4 -> o_clk high 2 cycles, low 2 cycles; o_tick every 4 cycles; o_running=1.
REQ-034 While running at 4, send N=6 during a high phase -> the high phase finishes at 2 cycles, then low 3 and high 3; o_div_cur=6 from the falling toggle; o_div_ready low until then.
REQ-035 Send N=5, then N=0 -> o_err=1 each time, o_div_cur unchanged at 4; after i_err_clr, o_err=0.
REQ-036 Deassert i_enable one cycle into a high phase at N=8 -> o_clk stays high 4 cycles total, falls, reaches OFF; o_running=0; no further o_tick.
REQ-037 Assert i_rst mid-high-phase while in PEND -> o_clk=0 without a clock edge; o_div_cur=4; the pending factor is never applied.
REQ-038 Apply N=2 and N=65534 in OFF, then enable -> o_clk period 2 cycles and 65534 cycles respectively; no counter wrap.
